// File: rtl/cv32e40p_rf_wb_arbiter.sv
// cv32e40p_rf_wb_arbiter
//   Writeback arbiter for the two write ports (A, B) of cv32e40p_register_file.
//   Merges the ALU (src0, never stalls), the LSU (src1, valid/ready) and the
//   APU/FPU (src2, buffered in a small FIFO) into at most two register writes
//   per cycle. The two ports never target the same address in one cycle, and
//   a FIFO head that waits STARVE_LIMIT cycles is promoted ahead of src1.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   src0_valid/addr/data_i      ALU result, always accepted
//   src1_valid/addr/data_i      LSU result; src1_ready_o (combinational) accepts it
//   src2_valid/addr/data_i      APU result; src2_ready_o (registered) = FIFO not full
//   waddr/wdata/we_a_o          register file write port A (registered)
//   waddr/wdata/we_b_o          register file write port B (registered)
//   conflict_cnt_o              address-conflict stall cycles (optional)
//   starve_cnt_o                starvation promotions (optional)
//
// Optional feature: define CV32E40P_WB_ARB_PERF_EN to add the two performance
// counters. Arbitration is identical with or without it.

module cv32e40p_rf_wb_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  src0_valid_i,
  input  logic [ADDR_WIDTH-1:0] src0_addr_i,
  input  logic [DATA_WIDTH-1:0] src0_data_i,
  input  logic                  src1_valid_i,
  output logic                  src1_ready_o,
  input  logic [ADDR_WIDTH-1:0] src1_addr_i,
  input  logic [DATA_WIDTH-1:0] src1_data_i,
  input  logic                  src2_valid_i,
  output logic                  src2_ready_o,
  input  logic [ADDR_WIDTH-1:0] src2_addr_i,
  input  logic [DATA_WIDTH-1:0] src2_data_i,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o,
  output logic                  we_b_o
`ifdef CV32E40P_WB_ARB_PERF_EN
  ,
  output logic [31:0]           conflict_cnt_o,
  output logic [31:0]           starve_cnt_o
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  src2_ready_q, src2_ready_d;
  logic [STV_W-1:0]      starve_q, starve_d;

  logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d, waddr_b_q, waddr_b_d;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;
  logic                  we_a_q, we_a_d, we_b_q, we_b_d;

  // candidate index: 0 = src0, 1 = src1, 2 = FIFO head
  logic [ADDR_WIDTH-1:0] cand_addr [3];
  logic [DATA_WIDTH-1:0] cand_data [3];
  logic [2:0]            cand_valid;
  logic [2:0]            grant;
  logic [ADDR_WIDTH-1:0] slot_addr [2];
  logic [DATA_WIDTH-1:0] slot_data [2];
  logic [1:0]            slot_n;
  logic                  promote, push, pop;
`ifdef CV32E40P_WB_ARB_PERF_EN
  logic                  conflict;
  logic [31:0]           conflict_cnt_q, conflict_cnt_d, starve_cnt_q, starve_cnt_d;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign cand_valid = {count_q != '0, src1_valid_i, src0_valid_i};
  assign cand_addr[0] = src0_addr_i;
  assign cand_addr[1] = src1_addr_i;
  assign cand_addr[2] = fifo_addr_q[rd_ptr_q];
  assign cand_data[0] = src0_data_i;
  assign cand_data[1] = src1_data_i;
  assign cand_data[2] = fifo_data_q[rd_ptr_q];

  assign promote = (starve_q == STV_W'(STARVE_LIMIT));

  // Walk the candidates in priority order filling slot A then slot B.
  // src1 is always evaluated as if valid so its ready reflects what would
  // happen, but it only occupies a slot when actually valid.
  always_comb begin
    int  c;
    logic ev, zr, mt, ok;
    slot_n    = 2'd0;
    slot_addr = '{default: '0};
    slot_data = '{default: '0};
    grant     = 3'b000;
`ifdef CV32E40P_WB_ARB_PERF_EN
    conflict  = 1'b0;
`endif
    for (int p = 0; p < 3; p++) begin
      c  = (p == 0) ? 0 : (((p == 1) != promote) ? 1 : 2);
      ev = (c == 1) ? 1'b1 : cand_valid[c];
      zr = (cand_addr[c] == '0);
      mt = ((slot_n != 2'd0) && (cand_addr[c] == slot_addr[0])) ||
           ((slot_n == 2'd2) && (cand_addr[c] == slot_addr[1]));
      ok = ev && (zr || (!mt && (slot_n != 2'd2)));
      grant[c] = ok;
`ifdef CV32E40P_WB_ARB_PERF_EN
      if (cand_valid[c] && (c != 0) && !zr && mt) conflict = 1'b1;
`endif
      if (ok && cand_valid[c] && !zr) begin
        slot_addr[slot_n[0]] = cand_addr[c];
        slot_data[slot_n[0]] = cand_data[c];
        slot_n = slot_n + 2'd1;
      end
    end
  end

  assign src1_ready_o = grant[1];
  assign pop  = grant[2];
  assign push = src2_valid_i && src2_ready_q;

  always_comb begin
    wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d     = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    src2_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    if ((count_q == '0) || pop)  starve_d = '0;
    else if (promote)            starve_d = starve_q;
    else                         starve_d = starve_q + 1'b1;

    we_a_d    = (slot_n != 2'd0);
    we_b_d    = (slot_n == 2'd2);
    waddr_a_d = we_a_d ? slot_addr[0] : waddr_a_q;
    wdata_a_d = we_a_d ? slot_data[0] : wdata_a_q;
    waddr_b_d = we_b_d ? slot_addr[1] : waddr_b_q;
    wdata_b_d = we_b_d ? slot_data[1] : wdata_b_q;
  end

  // storage needs no reset: count_q gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= src2_addr_i;
      fifo_data_q[wr_ptr_q] <= src2_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      src2_ready_q <= 1'b1;
      starve_q     <= '0;
      waddr_a_q    <= '0;
      wdata_a_q    <= '0;
      we_a_q       <= 1'b0;
      waddr_b_q    <= '0;
      wdata_b_q    <= '0;
      we_b_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      src2_ready_q <= src2_ready_d;
      starve_q     <= starve_d;
      waddr_a_q    <= waddr_a_d;
      wdata_a_q    <= wdata_a_d;
      we_a_q       <= we_a_d;
      waddr_b_q    <= waddr_b_d;
      wdata_b_q    <= wdata_b_d;
      we_b_q       <= we_b_d;
    end
  end

  assign src2_ready_o = src2_ready_q;
  assign waddr_a_o    = waddr_a_q;
  assign wdata_a_o    = wdata_a_q;
  assign we_a_o       = we_a_q;
  assign waddr_b_o    = waddr_b_q;
  assign wdata_b_o    = wdata_b_q;
  assign we_b_o       = we_b_q;

`ifdef CV32E40P_WB_ARB_PERF_EN
  always_comb begin
    conflict_cnt_d = conflict_cnt_q + {31'd0, conflict};
    starve_cnt_d   = starve_cnt_q + {31'd0, promote && pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_q <= '0;
      starve_cnt_q   <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      starve_cnt_q   <= starve_cnt_d;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
  assign starve_cnt_o   = starve_cnt_q;
`endif

endmodule

// File: tb/tb_cv32e40p_rf_wb_arbiter.sv
module tb_cv32e40p_rf_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        src0_valid, src1_valid, src2_valid;
  logic [5:0]  src0_addr, src1_addr, src2_addr;
  logic [31:0] src0_data, src1_data, src2_data;
  logic        src1_ready_o, src2_ready_o;
  logic [5:0]  waddr_a_o, waddr_b_o;
  logic [31:0] wdata_a_o, wdata_b_o;
  logic        we_a_o, we_b_o;
`ifdef CV32E40P_WB_ARB_PERF_EN
  logic [31:0] conflict_cnt_o, starve_cnt_o;
`endif

  cv32e40p_rf_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .src0_valid_i(src0_valid), .src0_addr_i(src0_addr), .src0_data_i(src0_data),
    .src1_valid_i(src1_valid), .src1_ready_o(src1_ready_o),
    .src1_addr_i(src1_addr), .src1_data_i(src1_data),
    .src2_valid_i(src2_valid), .src2_ready_o(src2_ready_o),
    .src2_addr_i(src2_addr), .src2_data_i(src2_data),
    .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o), .we_a_o(we_a_o),
    .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o), .we_b_o(we_b_o)
`ifdef CV32E40P_WB_ARB_PERF_EN
    , .conflict_cnt_o(conflict_cnt_o), .starve_cnt_o(starve_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } ent_t;

  int checks = 0;
  int errors = 0;

  // reference model state
  ent_t        m_fifo[$];
  int          m_starve;
  bit          m_ready2;
  bit          m_we_a, m_we_b;
  logic [5:0]  m_addr_a, m_addr_b;
  logic [31:0] m_data_a, m_data_b;
  logic [31:0] m_conf, m_stv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_starve = 0; m_ready2 = 1'b1;
    m_we_a = 0; m_we_b = 0;
    m_addr_a = '0; m_addr_b = '0; m_data_a = '0; m_data_b = '0;
    m_conf = '0; m_stv = '0;
  endtask

  function automatic bit hit(input logic [5:0] a, input ent_t w[$]);
    foreach (w[i]) if (w[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  // a write fits if it is to x0, or the address is fresh and a port is free
  function automatic bit fits(input logic [5:0] a, input ent_t w[$]);
    return (a == 0) || (!hit(a, w) && w.size() < 2);
  endfunction

  task automatic set_in(input bit v0, input logic [5:0] a0, input logic [31:0] d0,
                        input bit v1, input logic [5:0] a1, input logic [31:0] d1,
                        input bit v2, input logic [5:0] a2, input logic [31:0] d2);
    src0_valid = v0; src0_addr = a0; src0_data = d0;
    src1_valid = v1; src1_addr = a1; src1_data = d1;
    src2_valid = v2; src2_addr = a2; src2_data = d2;
  endtask

  // One clock cycle: predict, check ready before the edge, clock, check outputs.
  task automatic tick();
    ent_t wr[$];
    ent_t h, e1;
    bit   promote, h_avail, h_ok, s1_ok, conf, push;
    #1;
    promote = (m_starve == LIMIT);
    h_avail = (m_fifo.size() > 0);
    h_ok = 0; s1_ok = 0; conf = 0;
    if (src0_valid && src0_addr != 0) wr.push_back('{a: src0_addr, d: src0_data});
    if (h_avail) h = m_fifo[0];
    e1 = '{a: src1_addr, d: src1_data};
    if (promote && h_avail) begin
      h_ok = fits(h.a, wr);
      if (h.a != 0 && hit(h.a, wr)) conf = 1;
      if (h_ok && h.a != 0) wr.push_back(h);
    end
    s1_ok = fits(e1.a, wr);
    if (src1_valid && e1.a != 0 && hit(e1.a, wr)) conf = 1;
    if (src1_valid && s1_ok && e1.a != 0) wr.push_back(e1);
    if (!promote && h_avail) begin
      h_ok = fits(h.a, wr);
      if (h.a != 0 && hit(h.a, wr)) conf = 1;
      if (h_ok && h.a != 0) wr.push_back(h);
    end
    push = src2_valid && m_ready2;
    check("src1_ready", {31'd0, src1_ready_o}, {31'd0, s1_ok});
    check("src2_ready", {31'd0, src2_ready_o}, {31'd0, m_ready2});

    @(posedge clk);
    if (h_ok) void'(m_fifo.pop_front());
    if (!h_avail || h_ok) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
    if (conf) m_conf++;
    if (promote && h_ok) m_stv++;
    if (push) m_fifo.push_back('{a: src2_addr, d: src2_data});
    m_ready2 = (m_fifo.size() < DEPTH);
    m_we_a = (wr.size() >= 1);
    m_we_b = (wr.size() >= 2);
    if (m_we_a) begin m_addr_a = wr[0].a; m_data_a = wr[0].d; end
    if (m_we_b) begin m_addr_b = wr[1].a; m_data_b = wr[1].d; end

    #1;
    check("we_a", {31'd0, we_a_o}, {31'd0, m_we_a});
    check("we_b", {31'd0, we_b_o}, {31'd0, m_we_b});
    check("waddr_a", {26'd0, waddr_a_o}, {26'd0, m_addr_a});
    check("wdata_a", wdata_a_o, m_data_a);
    check("waddr_b", {26'd0, waddr_b_o}, {26'd0, m_addr_b});
    check("wdata_b", wdata_b_o, m_data_b);
    if (we_a_o && we_b_o) begin
      checks++;
      assert (waddr_a_o != waddr_b_o) else begin
        errors++;
        $error("FAIL port_distinct observed=%0h expected=not %0h", waddr_b_o, waddr_a_o);
      end
    end
`ifdef CV32E40P_WB_ARB_PERF_EN
    check("conflict_cnt", conflict_cnt_o, m_conf);
    check("starve_cnt", starve_cnt_o, m_stv);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("rst_we_a", {31'd0, we_a_o}, 32'd0);
    check("rst_we_b", {31'd0, we_b_o}, 32'd0);
    check("rst_waddr_a", {26'd0, waddr_a_o}, 32'd0);
    check("rst_wdata_b", wdata_b_o, 32'd0);
    check("rst_src2_ready", {31'd0, src2_ready_o}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // both ports used in one cycle
    set_in(1, 6'd3, 32'hA, 1, 6'd4, 32'hB, 0, 0, 0);
    #1 check("t1_ready", {31'd0, src1_ready_o}, 32'd1);
    tick();
    check("t1_a", {we_a_o, 25'd0, waddr_a_o, wdata_a_o[3:0]}, {1'b1, 25'd0, 6'd3, 4'hA});
    check("t1_b", {we_b_o, 25'd0, waddr_b_o, wdata_b_o[3:0]}, {1'b1, 25'd0, 6'd4, 4'hB});

    // same destination: src1 waits one cycle
    set_in(1, 6'd7, 32'h1, 1, 6'd7, 32'h2, 0, 0, 0);
    #1 check("t2_ready_blocked", {31'd0, src1_ready_o}, 32'd0);
    tick();
    check("t2_a", {we_a_o, we_b_o, waddr_a_o, wdata_a_o[23:0]}, {2'b10, 6'd7, 24'h1});
    set_in(0, 0, 0, 1, 6'd7, 32'h2, 0, 0, 0);
    #1 check("t2_ready_retry", {31'd0, src1_ready_o}, 32'd1);
    tick();
    check("t2_retry", {we_a_o, we_b_o, waddr_a_o, wdata_a_o[23:0]}, {2'b10, 6'd7, 24'h2});

    // x0 writes vanish; ports hold previous values
    set_in(1, 6'd0, 32'hF, 1, 6'd0, 32'hE, 0, 0, 0);
    #1 check("t4_ready", {31'd0, src1_ready_o}, 32'd1);
    tick();
    check("t4_we", {30'd0, we_a_o, we_b_o}, 32'd0);
    check("t4_hold_a", {26'd0, waddr_a_o}, 32'd7);

    // FIFO fills, head starves for LIMIT cycles, then is promoted
    set_in(1, 6'd1, 32'h11, 1, 6'd2, 32'h22, 1, 6'd10, 32'h100);
    tick();
    set_in(1, 6'd1, 32'h12, 1, 6'd2, 32'h23, 1, 6'd11, 32'h101);
    tick();
    check("t3_full", {31'd0, src2_ready_o}, 32'd0);
    set_in(1, 6'd1, 32'h13, 1, 6'd2, 32'h24, 1, 6'd12, 32'h102);
    tick();
    set_in(1, 6'd1, 32'h14, 1, 6'd2, 32'h25, 0, 0, 0);
    tick();
    tick();
    #1 check("t3_promoted_ready", {31'd0, src1_ready_o}, 32'd0);
    tick();
    check("t3_head_slot_b", {we_b_o, 25'd0, waddr_b_o}, {1'b1, 25'd0, 6'd10});
    check("t3_head_data", wdata_b_o, 32'h100);
`ifdef CV32E40P_WB_ARB_PERF_EN
    check("t6_conflict", conflict_cnt_o, 32'd1);
    check("t6_starve", starve_cnt_o, 32'd1);
`endif
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();

    // asynchronous reset with a full FIFO
    set_in(1, 6'd1, 32'h31, 1, 6'd2, 32'h32, 1, 6'd20, 32'h200);
    tick();
    set_in(1, 6'd1, 32'h33, 1, 6'd2, 32'h34, 1, 6'd21, 32'h201);
    tick();
    rst_n = 1'b0;
    #1;
    check("t5_we", {30'd0, we_a_o, we_b_o}, 32'd0);
    check("t5_src2_ready", {31'd0, src2_ready_o}, 32'd1);
    model_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (3) tick();
    check("t5_no_stale", {30'd0, we_a_o, we_b_o}, 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, 6'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 6'h20 : 6'h0), $urandom,
             $urandom_range(0, 2) != 0, 6'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 6'h20 : 6'h0), $urandom,
             $urandom_range(0, 1) != 0, 6'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 6'h20 : 6'h0), $urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
